// File: rtl/asrv32_fetch_pkg.sv
// asrv32_fetch_pkg: shared constants, FSM encoding and helpers of the fetch stage
package asrv32_fetch_pkg;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int FETCH_STATE_WIDTH = 2;

    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STALLED = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/asrv32_fetch_if.sv
// asrv32_fetch_if: instruction-memory bus and decoder handoff of the fetch stage
interface asrv32_fetch_if;
    logic [31:0] iaddr;
    logic        stb_inst;
    logic        ack_inst;
    logic [31:0] mem_inst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        stall;
    logic        change_pc;
    logic [31:0] new_pc;

    modport master (
        output iaddr, stb_inst, inst, pc, valid,
        input  ack_inst, mem_inst, stall, change_pc, new_pc
    );

    modport slave (
        input  iaddr, stb_inst, inst, pc, valid,
        output ack_inst, mem_inst, stall, change_pc, new_pc
    );
endinterface

// File: rtl/asrv32_fetch_skid.sv
// asrv32_fetch_skid: one-entry {inst,pc} buffer catching the word acked while the decoder stalls
module asrv32_fetch_skid
    import asrv32_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] din_inst,
    input  logic [31:0] din_pc,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        full
);
    logic wr;

    assign wr = load && !full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            inst <= NOP_INST;
            pc   <= '0;
        end else begin
            full <= wr || (full && !(unload || clear));
            if (wr) begin
                inst <= din_inst;
                pc   <= din_pc;
            end
        end
    end
endmodule

// File: rtl/asrv32_fetch.sv
// asrv32_fetch: PC owner and single-outstanding instruction fetch feeding the decoder
// through a registered boundary, with a skid entry for stalls and redirect handling.
module asrv32_fetch
    import asrv32_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst_n,
    asrv32_fetch_if.master bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  iaddr_q, iaddr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  pend_q, pend_d;
    logic         skid_load, skid_unload, skid_clear, skid_full;
    logic [31:0]  skid_inst, skid_pc;

    asrv32_fetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .din_inst (bus.mem_inst),
        .din_pc   (iaddr_q),
        .inst     (skid_inst),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    assign bus.iaddr    = iaddr_q;
    assign bus.stb_inst = (state_q == FETCH) || (state_q == DISCARD);
    assign bus.inst     = inst_q;
    assign bus.pc       = pc_q;
    assign bus.valid    = valid_q;

    always_comb begin
        state_d     = state_q;
        iaddr_d     = iaddr_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        pend_d      = pend_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (bus.change_pc) iaddr_d = word_align(bus.new_pc);
            end
            FETCH: begin
                if (bus.change_pc) begin
                    valid_d = 1'b0;
                    if (bus.ack_inst) begin
                        iaddr_d = word_align(bus.new_pc);
                    end else begin
                        pend_d  = word_align(bus.new_pc);
                        state_d = DISCARD;
                    end
                end else if (bus.ack_inst && valid_q && bus.stall) begin
                    skid_load = !skid_full;
                    iaddr_d   = iaddr_q + 32'd4;
                    state_d   = STALLED;
                end else if (bus.ack_inst) begin
                    inst_d  = bus.mem_inst;
                    pc_d    = iaddr_q;
                    valid_d = 1'b1;
                    iaddr_d = iaddr_q + 32'd4;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                end
            end
            STALLED: begin
                if (bus.change_pc) begin
                    skid_clear = 1'b1;
                    valid_d    = 1'b0;
                    iaddr_d    = word_align(bus.new_pc);
                    state_d    = FETCH;
                end else if (!bus.stall) begin
                    inst_d      = skid_inst;
                    pc_d        = skid_pc;
                    valid_d     = 1'b1;
                    skid_unload = 1'b1;
                    state_d     = FETCH;
                end
            end
            DISCARD: begin
                // the in-flight word belongs to the abandoned path; the newest redirect wins
                if (bus.ack_inst) begin
                    iaddr_d = bus.change_pc ? word_align(bus.new_pc) : pend_q;
                    state_d = FETCH;
                end else if (bus.change_pc) begin
                    pend_d = word_align(bus.new_pc);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iaddr_q <= word_align(PC_RESET);
            inst_q  <= NOP_INST;
            pc_q    <= word_align(PC_RESET);
            valid_q <= 1'b0;
            pend_q  <= word_align(PC_RESET);
        end else begin
            state_q <= state_d;
            iaddr_q <= iaddr_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end
endmodule
